// File: rtl/regfile_dbg_pkg.sv
// Shared types and default sizes for the register-file debug sequencer.
package regfile_dbg_pkg;

  localparam int REG_SEL_W     = 5;
  localparam int REG_DATA_W    = 32;
  localparam int NUM_ARCH_REGS = 32;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    SETTLE,
    LOAD,
    SEND,
    RESUME
  } state_t;

endpackage

// File: rtl/regfile_dbg_ctrl.sv
// Debug sequencer: halts the core, lets writeback drain, walks the register
// file debug read port and streams each word over a valid/ready handshake.
module regfile_dbg_ctrl
  import regfile_dbg_pkg::*;
#(
  parameter int NUM_REGS   = NUM_ARCH_REGS,
  parameter int SEL_W      = REG_SEL_W,
  parameter int DATA_W     = REG_DATA_W,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_req,
  input  logic              single_req,
  input  logic [SEL_W-1:0]  single_sel,
  output logic              clk_enable,
  output logic [SEL_W-1:0]  dbg_reg_sel,
  input  logic [DATA_W-1:0] dbg_reg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_REGS - 1);
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t           state;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] end_idx;
  logic [3:0]       settle_cnt;

  // Sequencer FSM; every output is a register so no input reaches an output
  // combinationally. dbg_reg_sel is updated on entry to LOAD so the register
  // file read data is already valid during the LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      end_idx     <= '0;
      settle_cnt  <= '0;
      clk_enable  <= 1'b1;
      dbg_reg_sel <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dump_req) begin
            idx        <= '0;
            end_idx    <= LAST_IDX;
            clk_enable <= 1'b0;
            busy       <= 1'b1;
            state      <= HALT;
          end else if (single_req) begin
            idx        <= single_sel;
            end_idx    <= single_sel;
            clk_enable <= 1'b0;
            busy       <= 1'b1;
            state      <= HALT;
          end
        end
        HALT: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            dbg_reg_sel <= idx;
            state       <= LOAD;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        LOAD: begin
          out_data  <= dbg_reg_data;
          out_idx   <= idx;
          out_valid <= 1'b1;
          out_last  <= (idx == end_idx);
          state     <= SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx == end_idx) begin
              state <= RESUME;
            end else begin
              idx         <= idx + 1'b1;
              dbg_reg_sel <= idx + 1'b1;
              state       <= LOAD;
            end
          end
        end
        RESUME: begin
          clk_enable <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// Scoreboard bench for regfile_dbg_ctrl: stimulus pushes expected words,
// a monitor pops and compares them as the DUT presents them.
module tb_regfile_dbg_ctrl;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        dump_req;
  logic        single_req;
  logic [4:0]  single_sel;
  logic        clk_enable;
  logic [4:0]  dbg_reg_sel;
  logic [31:0] dbg_reg_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  exp_t        sb [$];

  int checks    = 0;
  int failures  = 0;
  int words_rx  = 0;
  int done_cnt  = 0;
  int hold_cnt  = 0;
  int stall_at  = -1;

  assign dbg_reg_data = regs[dbg_reg_sel];

  regfile_dbg_ctrl #(
    .NUM_REGS  (32),
    .SEL_W     (5),
    .DATA_W    (32),
    .SETTLE_CYC(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dump_req    (dump_req),
    .single_req  (single_req),
    .single_sel  (single_sel),
    .clk_enable  (clk_enable),
    .dbg_reg_sel (dbg_reg_sel),
    .dbg_reg_data(dbg_reg_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer: ready high except for a 5-cycle stall when out_idx hits stall_at.
  initial begin
    int stall_left;
    stall_left = 0;
    out_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) stall_left--;
      else if (stall_at >= 0 && out_valid && int'(out_idx) == stall_at) begin
        stall_left = 5;
        stall_at   = -1;
      end
      out_ready = (stall_left == 0);
    end
  end

  // Monitor: compares every presented word against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) done_cnt++;
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got idx %0d data %0h expected no word", out_idx, out_data);
        end else begin
          e = sb[0];
          check("word_data", out_data, e.data);
          check("word_idx", 32'(out_idx), 32'(e.idx));
          check("word_last", 32'(out_last), 32'(e.last));
          if (out_ready) begin
            void'(sb.pop_front());
            words_rx++;
          end else begin
            hold_cnt++;
          end
        end
      end
    end
  end

  task automatic push_dump();
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.data = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
      e.idx  = 5'(i);
      e.last = (i == 31);
      sb.push_back(e);
    end
  endtask

  task automatic push_one(input logic [31:0] data, input logic [4:0] idx);
    exp_t e;
    e.data = data;
    e.idx  = idx;
    e.last = 1'b1;
    sb.push_back(e);
  endtask

  // Request pulse for one cycle; the core must be running before and halted after.
  task automatic issue(input logic d, input logic s, input logic [4:0] sel);
    @(negedge clk);
    check("idle_clk_enable", 32'(clk_enable), 32'd1);
    dump_req   = d;
    single_req = s;
    single_sel = sel;
    @(negedge clk);
    dump_req   = 1'b0;
    single_req = 1'b0;
    check("halt_clk_enable", 32'(clk_enable), 32'd0);
    check("halt_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int exp_words, input int w0, input int d0,
                           input int budget, output int cyc);
    bit seen;
    int ce_high;
    seen    = 1'b0;
    ce_high = 0;
    cyc     = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else if (clk_enable) ce_high++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", budget);
    end
    check("resume_clk_enable", 32'(clk_enable), 32'd1);
    check("halt_held", 32'(ce_high), 32'd0);
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("word_count", 32'(words_rx - w0), 32'(exp_words));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected bench completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, cyc, lat, h0, guard;
    rst_n      = 1'b0;
    dump_req   = 1'b0;
    single_req = 1'b0;
    single_sel = '0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);

    repeat (3) @(negedge clk);
    check("rst_clk_enable", 32'(clk_enable), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dbg_reg_sel", 32'(dbg_reg_sel), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #2 rst_n = 1'b1;

    // Full dump with a 5-cycle stall on word 7.
    w0 = words_rx; d0 = done_cnt; h0 = hold_cnt;
    push_dump();
    stall_at = 7;
    issue(1'b1, 1'b0, 5'd0);
    wait_done(32, w0, d0, 400, cyc);
    check("stall_hold_cycles", 32'(hold_cnt - h0), 32'd5);

    // Single read of x5; select changes mid-transaction must be ignored.
    regs[5] = 32'hDEAD_BEEF;
    w0 = words_rx; d0 = done_cnt;
    push_one(32'hDEAD_BEEF, 5'd5);
    issue(1'b0, 1'b1, 5'd5);
    single_sel = 5'd9;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("single_latency", 32'(lat), 32'd5);
    wait_done(1, w0, d0, 100, cyc);

    // Single read of the last register.
    w0 = words_rx; d0 = done_cnt;
    push_one(32'h1000_001F, 5'd31);
    issue(1'b0, 1'b1, 5'd31);
    wait_done(1, w0, d0, 100, cyc);

    // Both requests together -> dump wins; a single_req while busy is dropped.
    regs[5] = 32'h1000_0005;
    w0 = words_rx; d0 = done_cnt;
    push_dump();
    issue(1'b1, 1'b1, 5'd5);
    repeat (8) @(negedge clk);
    single_sel = 5'd3;
    single_req = 1'b1;
    @(negedge clk);
    single_req = 1'b0;
    wait_done(32, w0, d0, 400, cyc);

    // Reset in the middle of a dump at word 12.
    d0 = done_cnt;
    push_dump();
    issue(1'b1, 1'b0, 5'd0);
    guard = 0;
    while (!(out_valid && out_idx == 5'd12) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("reach_idx12", 32'(out_idx), 32'd12);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_clk_enable", 32'(clk_enable), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dbg_reg_sel", 32'(dbg_reg_sel), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_out_idx", 32'(out_idx), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    #2 rst_n = 1'b1;

    // Fresh dump after reset restarts at x0 and takes 64 cycles LOAD..last handshake.
    w0 = words_rx; d0 = done_cnt;
    push_dump();
    issue(1'b1, 1'b0, 5'd0);
    wait_done(32, w0, d0, 400, cyc);
    check("dump_cycles", 32'(cyc), 32'd68);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
